// File: rtl/priority_encoder_16_4_serial.sv
// Serial priority encoder: captures a request vector and streams out the index
// of every set bit, highest first, one index per output handshake.
module priority_encoder_16_4_serial #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W:0]   count
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W:0]   count_q, count_d;

    logic [N-1:0]     above_set;
    logic [N-1:0]     is_top;
    logic [IDX_W-1:0] top_idx;
    logic             single_bit;
    logic [N-1:0]     capture_vec;
    logic             capture;
    logic             beat;

    function automatic logic [IDX_W:0] popcount(input logic [N-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // above_set[i] is 1 when any pending bit above position i is set, so
    // is_top isolates exactly the highest pending bit.
    assign above_set[N-1] = 1'b0;
    generate
        for (genvar gi = N - 2; gi >= 0; gi--) begin : g_above
            assign above_set[gi] = above_set[gi+1] | pending_q[gi+1];
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_top
            assign is_top[gi] = pending_q[gi] & ~above_set[gi];
        end
    endgenerate

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (is_top[i]) begin
                top_idx = top_idx | IDX_W'(i);
            end
        end
    end

    assign single_bit  = (|pending_q) && ~|(pending_q & (pending_q - N'(1)));
    assign capture_vec = en ? in : '0;
    assign capture     = in_valid && (state_q == IDLE);
    assign beat        = out_ready && (state_q == DRAIN);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    pending_d = capture_vec;
                    count_d   = popcount(capture_vec);
                    state_d   = (|capture_vec) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (beat) begin
                    pending_d = pending_q & ~is_top;
                    if (single_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Index and last flag read as zero whenever no beat is being offered.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DRAIN);
    assign out_idx   = out_valid ? top_idx : '0;
    assign out_last  = out_valid && single_bit;
    assign count     = count_q;

endmodule

// File: tb/tb_priority_encoder_16_4_serial.sv
// Bench for priority_encoder_16_4_serial: table of vectors plus hand sequences
// for backpressure, busy-input and asynchronous reset cases.
module tb_priority_encoder_16_4_serial;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sb_q[$];

    typedef struct {
        logic [15:0] vec;
        logic        en;
        int          exp_count;
    } vec_t;

    vec_t tbl[8];

    priority_encoder_16_4_serial #(.N(16), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_data),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_count);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_idx"}, 32'(out_idx), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_count"}, 32'(count), 32'(exp_count));
    endtask

    // Called on a negedge with the block idle; returns on the negedge after capture.
    task automatic capture(input logic [15:0] v, input logic e, input logic rdy);
        check("in_ready_pre_capture", 32'(in_ready), 1);
        in_data   = v;
        en        = e;
        in_valid  = 1'b1;
        out_ready = rdy;
        for (int i = 15; i >= 0; i--) begin
            if (e && v[i]) sb_q.push_back(4'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        en       = 1'($urandom);
    endtask

    task automatic drain_queue(input int budget, output int cycles);
        logic [3:0] exp;
        cycles = 0;
        while (sb_q.size() > 0 && cycles < budget) begin
            if (out_valid) begin
                exp = sb_q.pop_front();
                check("beat_idx", 32'(out_idx), 32'(exp));
                check("beat_last", 32'(out_last), (sb_q.size() == 0) ? 1 : 0);
            end
            @(negedge clk);
            cycles++;
        end
        if (sb_q.size() > 0) begin
            check("drain_timeout_left", 32'(sb_q.size()), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        int cyc;
        tbl[0] = '{16'h8001, 1'b1, 2};
        tbl[1] = '{16'hFFFF, 1'b1, 16};
        tbl[2] = '{16'h0000, 1'b1, 0};
        tbl[3] = '{16'h0101, 1'b1, 2};
        tbl[4] = '{16'h00F0, 1'b0, 0};
        tbl[5] = '{16'h8000, 1'b1, 1};
        tbl[6] = '{16'hA5A5, 1'b1, 8};
        tbl[7] = '{16'h0001, 1'b1, 1};

        rst       = 1'b1;
        in_data   = '0;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset", 0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            capture(tbl[r].vec, tbl[r].en, 1'b1);
            drain_queue(40, cyc);
            check("drain_cycles", 32'(cyc), 32'(tbl[r].exp_count));
            check_idle("post_drain", tbl[r].exp_count);
            $display("vec=%h en=%b count=%0d beats=%0d", tbl[r].vec, tbl[r].en, count, cyc);
            @(negedge clk);
            check("idle_hold_out_valid", 32'(out_valid), 0);
        end

        // Backpressure: index and last flag hold while out_ready is low.
        capture(16'h0024, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_idx", 32'(out_idx), 32'(sb_q[0]));
            check("bp_out_last", 32'(out_last), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain_queue(10, cyc);
        check("bp_drain_cycles", 32'(cyc), 2);
        check_idle("bp_done", 2);
        $display("vec=0024 backpressure count=%0d beats=%0d", count, cyc);

        // A new request during a drain waits until the block is idle again.
        capture(16'h0C00, 1'b1, 1'b1);
        in_data  = 16'h0001;
        en       = 1'b1;
        in_valid = 1'b1;
        check("busy_in_ready0", 32'(in_ready), 0);
        check("busy_idx11", 32'(out_idx), 32'(sb_q.pop_front()));
        check("busy_last0", 32'(out_last), 0);
        @(negedge clk);
        check("busy_in_ready1", 32'(in_ready), 0);
        check("busy_idx10", 32'(out_idx), 32'(sb_q.pop_front()));
        check("busy_last1", 32'(out_last), 1);
        @(negedge clk);
        check("busy_now_ready", 32'(in_ready), 1);
        check("busy_count_held", 32'(count), 2);
        sb_q.push_back(4'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_new_count", 32'(count), 1);
        drain_queue(10, cyc);
        check("busy_new_cycles", 32'(cyc), 1);
        check_idle("busy_done", 1);
        $display("vec=0C00 then 0001 during drain count=%0d beats=%0d", count, cyc);

        // Asynchronous reset mid-drain, between clock edges.
        capture(16'h0F00, 1'b1, 1'b1);
        check("ar_idx11", 32'(out_idx), 32'(sb_q.pop_front()));
        @(negedge clk);
        check("ar_idx10", 32'(out_idx), 32'(sb_q[0]));
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst", 0);
        #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_idle("after_rst", 0);
        @(negedge clk);
        check("after_rst_out_valid", 32'(out_valid), 0);
        $display("vec=0F00 async reset mid-drain count=%0d", count);

        capture(16'h0100, 1'b1, 1'b1);
        drain_queue(10, cyc);
        check("recover_cycles", 32'(cyc), 1);
        check_idle("recover", 1);
        $display("vec=0100 after reset count=%0d beats=%0d", count, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
